// File: rtl/rdid_ctrl.sv
// rdid_ctrl: SPI mode-0 master that issues one JEDEC RDID (0x9F) and captures the 3-byte ID.
// Optional RDID_CHECK_EN adds id_match, comparing the manufacturer byte against EXPECTED_MFR.
module rdid_ctrl #(
  parameter int          CLK_DIV      = 2,
  parameter logic [7:0]  EXPECTED_MFR = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       spi_miso,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       busy,
  output logic       done,
  output logic [7:0] id_mfr,
  output logic [7:0] id_type,
  output logic [7:0] id_cap
`ifdef RDID_CHECK_EN
  ,
  output logic       id_match
`endif
);

  // state    | meaning
  // IDLE     | waiting for start, cs_n high
  // CS_SETUP | cs_n low, sclk low for CLK_DIV cycles before the first edge
  // SHIFT    | 32 sclk periods: opcode out, then 24 ID bits in
  // CS_HOLD  | cs_n still low, sclk low for CLK_DIV cycles after the last edge
  // CS_GAP   | cs_n high, busy held for CLK_DIV cycles (minimum deselect time)
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_GAP} state_t;

  localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LOAD = DW'(CLK_DIV - 1);
  localparam logic [7:0]     OPCODE   = 8'h9F;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic [23:0]   shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      id_mfr   <= '0;
      id_type  <= '0;
      id_cap   <= '0;
`ifdef RDID_CHECK_EN
      id_match <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CS_SETUP;
            spi_cs_n <= 1'b0;
            busy     <= 1'b1;
            spi_mosi <= OPCODE[7];
            div_cnt  <= DIV_LOAD;
            bit_cnt  <= '0;
          end
        end
        CS_SETUP: begin
          if (div_cnt == '0) begin
            state   <= SHIFT;
            div_cnt <= DIV_LOAD;
            bit_cnt <= '0;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt <= DIV_LOAD;
            if (!spi_sclk) begin
              spi_sclk <= 1'b1;
              // the first 8 sampled bits arrive while the opcode is still going out
              if (bit_cnt >= 5'd8) shreg <= {shreg[22:0], spi_miso};
            end else begin
              spi_sclk <= 1'b0;
              spi_mosi <= (bit_cnt < 5'd7) ? OPCODE[3'd6 - bit_cnt[2:0]] : 1'b0;
              if (bit_cnt == 5'd31) state <= CS_HOLD;
              else                  bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        CS_HOLD: begin
          if (div_cnt == '0) begin
            state    <= CS_GAP;
            div_cnt  <= DIV_LOAD;
            spi_cs_n <= 1'b1;
            done     <= 1'b1;
            id_mfr   <= shreg[23:16];
            id_type  <= shreg[15:8];
            id_cap   <= shreg[7:0];
`ifdef RDID_CHECK_EN
            id_match <= (shreg[23:16] == EXPECTED_MFR);
`endif
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        CS_GAP: begin
          if (div_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rdid_ctrl.sv
// Bench for rdid_ctrl: two instances (CLK_DIV=2 and 1) talking to a behavioural RDID flash model.
module tb_rdid_ctrl;

  int passed = 0;
  int total  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset [2];
  logic       start [2];
  logic       miso  [2];
  logic       cs_n  [2];
  logic       sclk  [2];
  logic       mosi  [2];
  logic       busy  [2];
  logic       done  [2];
  logic [7:0] mfr   [2];
  logic [7:0] typ   [2];
  logic [7:0] cap   [2];
`ifdef RDID_CHECK_EN
  logic       match [2];
`endif

  logic [23:0] flash_id [2];

  rdid_ctrl #(.CLK_DIV(2), .EXPECTED_MFR(8'h20)) u_div2 (
    .clk(clk), .reset(reset[0]), .start(start[0]), .spi_miso(miso[0]),
    .spi_cs_n(cs_n[0]), .spi_sclk(sclk[0]), .spi_mosi(mosi[0]),
    .busy(busy[0]), .done(done[0]),
    .id_mfr(mfr[0]), .id_type(typ[0]), .id_cap(cap[0])
`ifdef RDID_CHECK_EN
    , .id_match(match[0])
`endif
  );

  rdid_ctrl #(.CLK_DIV(1), .EXPECTED_MFR(8'h20)) u_div1 (
    .clk(clk), .reset(reset[1]), .start(start[1]), .spi_miso(miso[1]),
    .spi_cs_n(cs_n[1]), .spi_sclk(sclk[1]), .spi_mosi(mosi[1]),
    .busy(busy[1]), .done(done[1]),
    .id_mfr(mfr[1]), .id_type(typ[1]), .id_cap(cap[1])
`ifdef RDID_CHECK_EN
    , .id_match(match[1])
`endif
  );

  function automatic int div_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Flash bit n of a transaction: opcode phase is garbage, then 24 ID bits MSB first.
  function automatic logic flash_bit(input int k, input int n);
    if (n < 8)  return 1'($urandom);
    if (n < 32) return flash_id[k][31 - n];
    return 1'b0;
  endfunction

  int          nrise     [2] = '{0, 0};
  int          mcyc      [2] = '{0, 0};
  int          run_low   [2] = '{0, 0};
  int          low_len   [2] = '{0, 0};
  int          run_high  [2] = '{0, 0};
  int          gap_len   [2] = '{0, 0};
  int          rises     [2] = '{0, 0};
  int          falls     [2] = '{0, 0};
  int          dones     [2] = '{0, 0};
  int          done_cyc  [2] = '{0, 0};
  int          bfall_cyc [2] = '{0, 0};
  logic [31:0] mosi_bits [2] = '{32'h0, 32'h0};
  logic        p_cs      [2] = '{1'b1, 1'b1};
  logic        p_sclk    [2] = '{1'b0, 1'b0};
  logic        p_busy    [2] = '{1'b0, 1'b0};

  for (genvar g = 0; g < 2; g++) begin : g_env
    // mode-0 flash: shifts out on falling sclk, next bit ready before each rising edge
    always @(posedge cs_n[g] or negedge cs_n[g] or posedge sclk[g] or negedge sclk[g]) begin
      if (cs_n[g] !== 1'b0) begin
        nrise[g] = 0;
        miso[g]  = 1'($urandom);
      end else if (sclk[g] === 1'b1) begin
        nrise[g]++;
      end else begin
        miso[g] = flash_bit(g, nrise[g]);
      end
    end

    always @(negedge clk) begin
      mcyc[g]++;
      if (cs_n[g] === 1'b0) begin
        if (p_cs[g]) begin
          falls[g]++;
          gap_len[g] = run_high[g];
        end
        run_low[g]++;
        run_high[g] = 0;
      end else begin
        if (!p_cs[g]) low_len[g] = run_low[g];
        run_low[g] = 0;
        run_high[g]++;
      end
      if (sclk[g] === 1'b1 && !p_sclk[g] && cs_n[g] === 1'b0) begin
        rises[g]++;
        mosi_bits[g] = {mosi_bits[g][30:0], mosi[g]};
      end
      if (done[g] === 1'b1) begin
        dones[g]++;
        done_cyc[g] = mcyc[g];
      end
      if (busy[g] === 1'b0 && p_busy[g]) bfall_cyc[g] = mcyc[g];
      p_cs[g]   = (cs_n[g] !== 1'b0);
      p_sclk[g] = (sclk[g] === 1'b1);
      p_busy[g] = (busy[g] === 1'b1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, k, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag, input int k);
    check({tag, "_cs_n"}, k, 32'(cs_n[k]), 32'd1);
    check({tag, "_sclk"}, k, 32'(sclk[k]), 32'd0);
    check({tag, "_mosi"}, k, 32'(mosi[k]), 32'd0);
    check({tag, "_busy"}, k, 32'(busy[k]), 32'd0);
    check({tag, "_done"}, k, 32'(done[k]), 32'd0);
    check({tag, "_ids"},  k, {8'h0, mfr[k], typ[k], cap[k]}, 32'h0);
`ifdef RDID_CHECK_EN
    check({tag, "_match"}, k, 32'(match[k]), 32'd0);
`endif
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (busy[k] !== 1'b0 && n < 400) begin
      step(1);
      n++;
    end
    step(2);
  endtask

  task automatic run_txn(input int k, input logic [23:0] id);
    int d0, r0, n;
    flash_id[k] = id;
    d0 = dones[k];
    r0 = rises[k];
    start[k] = 1'b1;
    step(1);
    start[k] = 1'b0;
    n = 0;
    while (dones[k] == d0 && n < 2000) begin
      step(1);
      n++;
    end
    wait_idle(k);
    check("done_once",   k, 32'(dones[k] - d0), 32'd1);
    check("busy_idle",   k, 32'(busy[k]), 32'd0);
    check("id_mfr",      k, 32'(mfr[k]), 32'(id[23:16]));
    check("id_type",     k, 32'(typ[k]), 32'(id[15:8]));
    check("id_cap",      k, 32'(cap[k]), 32'(id[7:0]));
    check("cs_low_len",  k, 32'(low_len[k]), 32'(66 * div_of(k)));
    check("sclk_rises",  k, 32'(rises[k] - r0), 32'd32);
    check("mosi_bits",   k, mosi_bits[k], 32'h9F00_0000);
    check("busy_after_done", k, 32'(bfall_cyc[k] - done_cyc[k]), 32'(div_of(k)));
`ifdef RDID_CHECK_EN
    check("id_match",    k, 32'(match[k]), 32'(id[23:16] == 8'h20));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, f0, r0, n;
    logic [23:0] id;

    // reset held with start asserted: reset must win
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1;
      start[k] = 1'b1;
      flash_id[k] = 24'h0;
    end
    step(5);
    for (int k = 0; k < 2; k++) begin
      check_reset_outputs("reset", k);
      check("reset_no_cs", k, 32'(falls[k]), 32'd0);
      check("reset_no_sclk", k, 32'(rises[k]), 32'd0);
      start[k] = 1'b0;
      reset[k] = 1'b0;
    end
    step(2);

    run_txn(0, 24'h20BA18);
    run_txn(0, 24'hC22018);

    // start held high: back-to-back transactions, nothing queued while busy
    id = 24'($urandom);
    flash_id[0] = id;
    f0 = falls[0];
    d0 = dones[0];
    start[0] = 1'b1;
    step(400);
    check("held_cs_falls", 0, 32'(falls[0] - f0), 32'd3);
    check("held_dones",    0, 32'(dones[0] - d0), 32'd2);
    check("held_cs_gap",   0, 32'(gap_len[0]), 32'd3);
    check("held_low_len",  0, 32'(low_len[0]), 32'd132);
    check("held_mfr",      0, 32'(mfr[0]), 32'(id[23:16]));
    start[0] = 1'b0;
    wait_idle(0);
    check("held_final_dones", 0, 32'(dones[0] - d0), 32'd3);

    // reset in the middle of SHIFT while bit 15 is in its high phase
    flash_id[0] = 24'h5A5A5A;
    d0 = dones[0];
    r0 = rises[0];
    start[0] = 1'b1;
    step(1);
    start[0] = 1'b0;
    n = 0;
    while (rises[0] - r0 < 16 && n < 2000) begin
      step(1);
      n++;
    end
    check("pre_reset_sclk_high", 0, 32'(sclk[0]), 32'd1);
    reset[0] = 1'b1;
    step(1);
    reset[0] = 1'b0;
    check_reset_outputs("midreset", 0);
    step(3);
    check("midreset_no_done", 0, 32'(dones[0] - d0), 32'd0);
    check("midreset_cs_idle", 0, 32'(cs_n[0]), 32'd1);
    run_txn(0, 24'($urandom));

    run_txn(1, 24'hEF4017);

    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 2; k++) begin
        id = {(($urandom % 2) == 0) ? 8'h20 : 8'($urandom), 16'($urandom)};
        run_txn(k, id);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
